ps2_kbd_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_byte_fifo.sv | 57 +++++
 rtl/ps2_kbd_tx.sv | 123 ++++++++++++
 tb/tb_ps2_kbd_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } ps2_tx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    // Odd parity: the returned bit makes the total count of ones in byte+parity odd.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO, 2**AW deep, with occupancy count and synchronous reset.
// Read data is the head entry, combinationally visible while not empty.
module ps2_byte_fifo #(
    parameter int AW = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queued bytes are framed as start, 8 data LSB-first,
// odd parity, stop, with the PS/2 clock derived from a clk_sys divider.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 960,
    parameter int GAP_HALVES = 4,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               ps2_kbd_clk,
    output logic               ps2_kbd_data,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    ps2_tx_state_t state;
    logic [15:0]   div;
    logic          tick;
    logic [10:0]   shreg;
    logic [3:0]    bit_idx;
    logic          phase;
    logic [7:0]    gap_cnt;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          pop;

    assign tick       = (div == 16'(CLK_DIV - 1));
    assign pop        = (state == LOAD);
    assign byte_ready = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    ps2_byte_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (byte_valid),
        .din     (byte_i),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            div          <= '0;
            shreg        <= '1;
            bit_idx      <= '0;
            phase        <= 1'b0;
            gap_cnt      <= '0;
            ps2_kbd_clk  <= 1'b1;
            ps2_kbd_data <= 1'b1;
        end else begin
            // Divider held at zero through LOAD so every frame starts a full half-period later.
            if (state == IDLE || state == LOAD || tick) begin
                div <= '0;
            end else begin
                div <= div + 16'd1;
            end

            case (state)
                IDLE: begin
                    ps2_kbd_clk  <= 1'b1;
                    ps2_kbd_data <= 1'b1;
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg        <= {1'b1, ps2_odd_parity(fifo_dout), fifo_dout, 1'b0};
                    ps2_kbd_clk  <= 1'b1;
                    ps2_kbd_data <= 1'b0;
                    bit_idx      <= '0;
                    phase        <= 1'b0;
                    state        <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            ps2_kbd_clk <= 1'b0;
                            phase       <= 1'b1;
                        end else begin
                            // Data only moves on the rising half so it is stable at the falling edge.
                            ps2_kbd_clk <= 1'b1;
                            phase       <= 1'b0;
                            if (bit_idx == 4'(PS2_FRAME_BITS - 1)) begin
                                ps2_kbd_data <= 1'b1;
                                gap_cnt      <= '0;
                                state        <= GAP;
                            end else begin
                                bit_idx      <= bit_idx + 4'd1;
                                ps2_kbd_data <= shreg[bit_idx + 4'd1];
                            end
                        end
                    end
                end
                GAP: begin
                    ps2_kbd_clk  <= 1'b1;
                    ps2_kbd_data <= 1'b1;
                    if (tick) begin
                        if (gap_cnt == 8'(GAP_HALVES - 1)) begin
                            state <= fifo_empty ? IDLE : LOAD;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: decodes frames from the falling PS/2 clock edges and compares
// them and their timing against a byte-queue reference model.
module tb_ps2_kbd_tx;

    localparam int D = 4;
    localparam int G = 2;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] byte_i;
    logic       byte_valid;
    logic       byte_ready;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic       busy;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int   cyc;
        logic d;
    } fall_t;

    fall_t      fall_q[$];
    logic [7:0] exp_q[$];
    logic       ps2_prev = 1'b1;

    ps2_kbd_tx #(
        .CLK_DIV    (D),
        .GAP_HALVES (G),
        .FIFO_AW    (3)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .byte_i       (byte_i),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Receiver view: record the data line at every falling PS/2 clock edge.
    always @(negedge clk_sys) begin
        if (ps2_prev && !ps2_kbd_clk) begin
            fall_q.push_back('{cyc, ps2_kbd_data});
        end
        ps2_prev = ps2_kbd_clk;
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int         ones;
        logic [10:0] f;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones  += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_falls();
        @(posedge clk_sys);
        #1;
        fall_q.delete();
        @(negedge clk_sys);
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic push_byte(input logic [7:0] b, output int acc);
        for (int i = 0; i < 200; i++) begin
            if (byte_ready) break;
            @(negedge clk_sys);
        end
        chk("push_ready", byte_ready, 1);
        byte_i     = b;
        byte_valid = 1'b1;
        @(negedge clk_sys);
        byte_valid = 1'b0;
        acc        = cyc;
    endtask

    task automatic recv_frame(output logic [10:0] bits, output int t0);
        bit    ok;
        fall_t f;
        ok   = 1'b0;
        bits = '0;
        t0   = 0;
        for (int i = 0; i < 3000; i++) begin
            if (fall_q.size() >= 11) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        chk("frame_avail", ok, 1);
        if (ok) begin
            t0 = fall_q[0].cyc;
            for (int k = 0; k < 11; k++) begin
                f       = fall_q.pop_front();
                bits[k] = f.d;
            end
        end
    endtask

    task automatic recv_expected(input string tag);
        logic [10:0] bits;
        logic [7:0]  b;
        int          t0;
        recv_frame(bits, t0);
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        chk(tag, bits, frame_of(b));
    endtask

    task automatic wait_idle(output int t);
        for (int i = 0; i < 5000; i++) begin
            if (!busy) break;
            @(negedge clk_sys);
        end
        t = cyc;
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        logic [10:0] bits_a;
        logic [10:0] bits_b;
        int          acc;
        int          ta;
        int          tb;
        int          t_idle;
        int          n_acc;
        int          bad;
        logic [7:0]  base;
        logic [7:0]  rb;

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_i     = 8'h00;
        repeat (3) @(negedge clk_sys);
        chk("rst_clk", ps2_kbd_clk, 1);
        chk("rst_data", ps2_kbd_data, 1);
        chk("rst_ready", byte_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Single byte 0x1C with frame timing.
        clear_falls();
        push_byte(8'h1C, acc);
        recv_frame(bits_a, ta);
        chk("single_1c_bits", bits_a, 11'h438);
        chk("single_first_fall", ta - acc, D + 2);
        wait_idle(t_idle);
        chk("single_busy_fall", t_idle - ta, (21 + G) * D);
        chk("single_count", fifo_count, 0);

        // Back-to-back 0xF0, 0x1C.
        clear_falls();
        push_byte(8'hF0, acc);
        push_byte(8'h1C, acc);
        recv_frame(bits_a, ta);
        recv_frame(bits_b, tb);
        chk("b2b_f0", bits_a, frame_of(8'hF0));
        chk("b2b_f0_parity", bits_a[9], 1);
        chk("b2b_1c", bits_b, frame_of(8'h1C));
        chk("b2b_spacing", tb - ta, (22 + G) * D + 1);
        wait_idle(t_idle);

        // byte_valid held for 10 cycles with incrementing bytes.
        clear_falls();
        base  = 8'($urandom);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            byte_i     = base + 8'(i);
            byte_valid = 1'b1;
            if (byte_ready) begin
                exp_q.push_back(base + 8'(i));
                n_acc++;
            end
            @(negedge clk_sys);
        end
        byte_valid = 1'b0;
        chk("hold_accepted", n_acc, 9);
        chk("hold_count", fifo_count, 8);
        chk("hold_ready", byte_ready, 0);
        for (int i = 0; i < 9; i++) recv_expected("hold_frame");
        wait_idle(t_idle);

        // Push coinciding with the LOAD pop keeps the count unchanged.
        clear_falls();
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            exp_q.push_back(rb);
            push_byte(rb, acc);
        end
        for (int i = 0; i < 500; i++) begin
            if (fall_q.size() > 0) break;
            @(negedge clk_sys);
        end
        chk("pp_first_fall", fall_q.size() > 0, 1);
        ta = (fall_q.size() > 0) ? fall_q[0].cyc : cyc;
        for (int i = 0; i < 500; i++) begin
            if (cyc >= ta + (22 + G) * D + 1 - D - 1) break;
            @(negedge clk_sys);
        end
        chk("pp_count_before", fifo_count, 3);
        rb = 8'($urandom);
        exp_q.push_back(rb);
        byte_i     = rb;
        byte_valid = 1'b1;
        @(negedge clk_sys);
        byte_valid = 1'b0;
        chk("pp_count_after", fifo_count, 3);
        for (int i = 0; i < 5; i++) recv_expected("pp_frame");
        wait_idle(t_idle);

        // Reset during bit 5 of a frame with bytes still queued.
        clear_falls();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), acc);
        for (int i = 0; i < 1000; i++) begin
            if (fall_q.size() >= 6) break;
            @(negedge clk_sys);
        end
        chk("mid_bit5_reached", fall_q.size() >= 6, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("mid_rst_clk", ps2_kbd_clk, 1);
        chk("mid_rst_data", ps2_kbd_data, 1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        clear_falls();
        repeat (300) @(negedge clk_sys);
        chk("mid_no_edges", fall_q.size(), 0);

        // Random bytes with random spacing between pushes.
        clear_falls();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk_sys);
            rb = 8'($urandom);
            exp_q.push_back(rb);
            push_byte(rb, acc);
        end
        for (int i = 0; i < 6; i++) recv_expected("rand_frame");
        wait_idle(t_idle);
        chk("rand_queue_drained", exp_q.size(), 0);

        // Long idle stretch.
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_sys);
            if (!(ps2_kbd_clk === 1'b1 && ps2_kbd_data === 1'b1 && busy === 1'b0)) bad++;
        end
        chk("idle_10000", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
